// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the memory/IO bus arbiter: FSM states, requester ids,
// default IO nibble and the one-hot access-control decode.
package mio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } mio_state_e;

  localparam logic        MIO_IF_ID      = 1'b0;
  localparam logic        MIO_DM_ID      = 1'b1;
  localparam logic [3:0]  IO_NIB_DEFAULT = 4'hF;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic        WRITE_ENABLE   = 1'b1;

  typedef struct packed {
    logic ior;
    logic iow;
    logic mw;
    logic mr;
  } mio_ctl_t;

  // Instruction fetch always reads memory-style, whatever space it addresses.
  function automatic mio_ctl_t ctl_decode(input logic id, input logic we, input logic io);
    mio_ctl_t c;
    c = '0;
    if (id == MIO_IF_ID) begin
      c.mr = 1'b1;
    end else if (io) begin
      if (we == WRITE_ENABLE) c.iow = 1'b1;
      else                    c.ior = 1'b1;
    end else begin
      if (we == WRITE_ENABLE) c.mw = 1'b1;
      else                    c.mr = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mio_wait_cnt.sv
// Loadable 3-bit wait-state down-counter; zero flags the final access cycle.
module mio_wait_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/mio_bus_arbiter.sv
// Arbitrates IF and DM onto the shared memory/IO access controller with wait states.
// Build option: MIO_RR_EN selects round-robin arbitration instead of fixed DM priority.
module mio_bus_arbiter
  import mio_bus_arbiter_pkg::*;
#(
  parameter logic [3:0]  IO_NIB   = IO_NIB_DEFAULT,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        ior_ctl_o,
  output logic        iow_ctl_o,
  output logic        mw_ctl_o,
  output logic        mr_ctl_o,
  output logic [31:0] m_iaddr_o,
  output logic [31:0] wm_idata_o,
  input  logic [31:0] rm_idata_i,
  output logic        stall_o
);

  mio_state_e  state_q, state_d;
  mio_ctl_t    ctl_q, ctl_d;
  logic        id_q, we_q;
  logic [31:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
  logic        if_ack_q, dm_ack_q;
  logic        grant, capture, cnt_load, cnt_dec, cnt_zero;
  logic        grant_dm, gnt_id, gnt_we, gnt_io;
  logic [31:0] gnt_addr;
  logic [2:0]  wait_load;

`ifdef MIO_RR_EN
  logic last_id_q;
  // Reset value IF means DM takes the first conflict.
  assign grant_dm = dm_req_i & (~if_req_i | (last_id_q == MIO_IF_ID));
`else
  assign grant_dm = dm_req_i;
`endif

  assign gnt_id    = grant_dm ? MIO_DM_ID : MIO_IF_ID;
  assign gnt_addr  = grant_dm ? dm_addr_i : if_addr_i;
  assign gnt_we    = grant_dm & dm_we_i;
  assign gnt_io    = (gnt_addr[31:28] == IO_NIB);
  assign wait_load = gnt_io ? 3'(IO_WAIT) : 3'(MEM_WAIT);

  mio_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (wait_load),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    ctl_d    = ctl_q;
    grant    = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          grant    = 1'b1;
          cnt_load = 1'b1;
          ctl_d    = ctl_decode(gnt_id, gnt_we, gnt_io);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          capture = 1'b1;
          ctl_d   = '0;
          state_d = ST_ACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        ctl_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctl_q      <= '0;
      id_q       <= MIO_IF_ID;
      we_q       <= 1'b0;
      addr_q     <= ZERO_WORD;
      wdata_q    <= ZERO_WORD;
      if_rdata_q <= ZERO_WORD;
      dm_rdata_q <= ZERO_WORD;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      if_ack_q <= capture & (id_q == MIO_IF_ID);
      dm_ack_q <= capture & (id_q == MIO_DM_ID);
      if (grant) begin
        id_q    <= gnt_id;
        we_q    <= gnt_we;
        addr_q  <= gnt_addr;
        wdata_q <= grant_dm ? dm_wdata_i : ZERO_WORD;
      end
      if (capture && !we_q) begin
        if (id_q == MIO_IF_ID) if_rdata_q <= rm_idata_i;
        else                   dm_rdata_q <= rm_idata_i;
      end
    end
  end

`ifdef MIO_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_id_q <= MIO_IF_ID;
    else if (grant) last_id_q <= gnt_id;
  end
`endif

  assign {ior_ctl_o, iow_ctl_o, mw_ctl_o, mr_ctl_o} = ctl_q;
  assign m_iaddr_o  = addr_q;
  assign wm_idata_o = wdata_q;
  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign if_ack_o   = if_ack_q;
  assign dm_ack_o   = dm_ack_q;
  assign stall_o    = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
